hash_result_scanner: RTL and testbench



---
 rtl/hash_result_scanner.sv | 123 ++++++++++++
 tb/tb_hash_result_scanner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hash_result_scanner.sv
// rtl/hash_result_scanner.sv - scans the nonce-hash result table for hits below target and the minimum word
module hash_result_scanner #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] output_addr,
  input  logic [31:0] target,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [7:0]  hit_count,
  output logic [7:0]  best_nonce,
  output logic [31:0] best_hash
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(NUM_NONCES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_mem_addr;
  logic [31:0] r_target;
  logic [7:0]  r_idx;
  logic        r_busy;
  logic        r_done;
  logic [7:0]  r_hit_count;
  logic [7:0]  r_best_nonce;
  logic [31:0] r_best_hash;

  logic w_accept;
  logic w_last;
  logic w_hit;
  logic w_better;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_state == S_SCAN) && (r_idx == LAST_IDX);
  assign w_hit    = mem_read_data < r_target;
  // Strict compare keeps the earliest index when the minimum repeats.
  assign w_better = mem_read_data < r_best_hash;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_PRIME;
      S_PRIME: w_next = S_SCAN;
      S_SCAN:  if (w_last) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_PRIME;
      default: w_next = S_IDLE;
    endcase
  end

  // The address runs one word ahead of the data because reads take a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_addr   <= 16'h0000;
      r_target     <= 32'h0000_0000;
      r_idx        <= 8'h00;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_hit_count  <= 8'h00;
      r_best_nonce <= 8'h00;
      r_best_hash  <= 32'hFFFF_FFFF;
    end else if (w_accept) begin
      r_mem_addr   <= output_addr;
      r_target     <= target;
      r_idx        <= 8'h00;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_hit_count  <= 8'h00;
      r_best_nonce <= 8'h00;
      r_best_hash  <= 32'hFFFF_FFFF;
    end else if (r_state == S_PRIME) begin
      r_mem_addr <= r_mem_addr + 16'h0001;
    end else if (r_state == S_SCAN) begin
      r_mem_addr <= r_mem_addr + 16'h0001;
      r_idx      <= r_idx + 8'h01;
      if (w_hit) begin
        r_hit_count <= r_hit_count + 8'h01;
      end
      if (w_better) begin
        r_best_hash  <= mem_read_data;
        r_best_nonce <= r_idx;
      end
      if (w_last) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  assign mem_clk        = clk;
  assign mem_we         = 1'b0;
  assign mem_write_data = 32'h0000_0000;
  assign mem_addr       = r_mem_addr;
  assign busy           = r_busy;
  assign done           = r_done;
  assign found          = (r_hit_count != 8'h00);
  assign hit_count      = r_hit_count;
  assign best_nonce     = r_best_nonce;
  assign best_hash      = r_best_hash;

endmodule

// File: tb/tb_hash_result_scanner.sv
// tb/tb_hash_result_scanner.sv - self-checking bench for hash_result_scanner
module tb_hash_result_scanner;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] output_addr = 16'h0;
  logic [31:0] target = 32'h0;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = 32'h0;
  logic        busy;
  logic        done;
  logic        found;
  logic [7:0]  hit_count;
  logic [7:0]  best_nonce;
  logic [31:0] best_hash;

  logic [31:0] mem [65536];

  int n_cmp = 0;
  int n_err = 0;

  hash_result_scanner #(.NUM_NONCES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .output_addr(output_addr),
    .target(target), .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy), .done(done), .found(found), .hit_count(hit_count),
    .best_nonce(best_nonce), .best_hash(best_hash)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_read_data <= mem[mem_addr];

  typedef struct {
    string       name;
    logic [15:0] base;
    logic [31:0] tgt;
    int          kind;
    int          chk_addr;
    int          exp_hit;
    int          exp_nonce;
    logic [31:0] exp_hash;
    int          exp_found;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int kind, input int i);
    case (kind)
      0: return 32'(i * 16 + 100);
      1: return 32'(32'hF0 - i);
      2: return ((i == 3) || (i == 9)) ? 32'h5 : 32'(32'h100 + i);
      3: return 32'hFFFF_FFFF;
      4: return 32'(1000 - 3 * i);
      5: return $urandom();
      default: return 32'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic fill(input logic [15:0] base, input int kind);
    logic [15:0] a;
    for (int i = 0; i < N; i++) begin
      a = base + 16'(i);
      mem[a] = word_of(kind, i);
    end
  endtask

  // Reference: count of hits, minimum value, then first index holding that minimum.
  task automatic model(input logic [15:0] base, input logic [31:0] tgt,
                       output int hit, output int nonce, output logic [31:0] best);
    logic [31:0] w [N];
    logic [15:0] a;
    hit = 0;
    for (int i = 0; i < N; i++) begin
      a = base + 16'(i);
      w[i] = mem[a];
      if (w[i] < tgt) hit++;
    end
    best = 32'hFFFF_FFFF;
    foreach (w[i]) if (w[i] < best) best = w[i];
    nonce = 0;
    for (int i = N - 1; i >= 0; i--) if (w[i] == best) nonce = i;
  endtask

  task automatic do_scan(input string name, input logic [15:0] base, input logic [31:0] tgt,
                         input int chk_addr, input int noise);
    int lat;
    int bad_we;
    lat = -1;
    bad_we = 0;
    @(negedge clk);
    output_addr = base;
    target = tgt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({name, ".done_drop"}, {31'b0, done}, 32'd0);
    chk({name, ".busy_rise"}, {31'b0, busy}, 32'd1);
    for (int j = 0; j < 40; j++) begin
      if (mem_we !== 1'b0 || mem_write_data !== 32'h0 || mem_clk !== clk) bad_we++;
      if (chk_addr != 0 && j < N) chk({name, ".addr_seq"}, {16'h0, mem_addr}, {16'h0, base + 16'(j)});
      if (done) begin
        start = 1'b0;
        lat = j;
        break;
      end
      if (noise != 0) begin
        output_addr = 16'($urandom());
        target = $urandom();
        start = ($urandom_range(0, 2) == 0);
      end
      @(negedge clk);
    end
    chk({name, ".latency"}, 32'(lat), 32'(N + 1));
    chk({name, ".mem_we_quiet"}, 32'(bad_we), 32'd0);
  endtask

  task automatic chk_results(input string name, input logic [15:0] base, input logic [31:0] tgt);
    int hit;
    int nonce;
    logic [31:0] best;
    model(base, tgt, hit, nonce, best);
    chk({name, ".hit_count"}, {24'h0, hit_count}, 32'(hit));
    chk({name, ".best_nonce"}, {24'h0, best_nonce}, 32'(nonce));
    chk({name, ".best_hash"}, best_hash, best);
    chk({name, ".found"}, {31'b0, found}, {31'b0, hit != 0});
    chk({name, ".busy_low"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, ".busy"}, {31'b0, busy}, 32'd0);
    chk({name, ".done"}, {31'b0, done}, 32'd0);
    chk({name, ".found"}, {31'b0, found}, 32'd0);
    chk({name, ".hit_count"}, {24'h0, hit_count}, 32'd0);
    chk({name, ".best_nonce"}, {24'h0, best_nonce}, 32'd0);
    chk({name, ".best_hash"}, best_hash, 32'hFFFF_FFFF);
    chk({name, ".mem_addr"}, {16'h0, mem_addr}, 32'd0);
  endtask

  vec_t vecs [5];

  initial begin
    logic [15:0] rb;
    logic [31:0] rt;
    vecs[0] = '{"ascend",  16'h0200, 32'h0000_0105, 0, 0, 11, 0,  32'h64,        1};
    vecs[1] = '{"descend", 16'h1000, 32'hFFFF_FFFF, 1, 0, 16, 15, 32'hE1,        1};
    vecs[2] = '{"dupmin",  16'h2000, 32'h0000_0000, 2, 0, 0,  3,  32'h5,         0};
    vecs[3] = '{"allones", 16'h3000, 32'hFFFF_FFFF, 3, 0, 0,  0,  32'hFFFF_FFFF, 0};
    vecs[4] = '{"wrap",    16'hFFF8, 32'h0000_03C0, 4, 1, 2,  15, 32'h3BB,       1};

    for (int i = 0; i < 65536; i++) mem[i] = 32'hDEAD_0000 | 32'(i);

    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b0;

    foreach (vecs[v]) begin
      fill(vecs[v].base, vecs[v].kind);
      do_scan(vecs[v].name, vecs[v].base, vecs[v].tgt, vecs[v].chk_addr, 0);
      chk({vecs[v].name, ".hit_count"}, {24'h0, hit_count}, 32'(vecs[v].exp_hit));
      chk({vecs[v].name, ".best_nonce"}, {24'h0, best_nonce}, 32'(vecs[v].exp_nonce));
      chk({vecs[v].name, ".best_hash"}, best_hash, vecs[v].exp_hash);
      chk({vecs[v].name, ".found"}, {31'b0, found}, 32'(vecs[v].exp_found));
      chk({vecs[v].name, ".done_held"}, {31'b0, done}, 32'd1);
    end

    // Back-to-back restart from DONE with a different target.
    do_scan("b2b", 16'h0200, 32'h0000_0200, 0, 0);
    chk_results("b2b", 16'h0200, 32'h0000_0200);

    // Reset in the middle of a scan, then a fresh scan with noisy inputs.
    fill(16'h0300, 0);
    @(negedge clk);
    output_addr = 16'h0300;
    target = 32'hFFFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_state("midreset");
    do_scan("after_reset", 16'h0300, 32'h0000_0100, 0, 1);
    chk_results("after_reset", 16'h0300, 32'h0000_0100);

    // Randomized scans against the reference model.
    for (int r = 0; r < 12; r++) begin
      rb = 16'($urandom());
      case ($urandom_range(0, 3))
        0: rt = 32'h0;
        1: rt = 32'hFFFF_FFFF;
        2: rt = 32'($urandom_range(0, 16));
        default: rt = $urandom();
      endcase
      fill(rb, (r % 2 == 0) ? 5 : 6);
      do_scan("rand", rb, rt, 0, r % 3);
      chk_results("rand", rb, rt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
